// File: rtl/operand_stack_if.sv
// operand_stack_if: stack-effect command and registered operand view between the ALU datapath and the stack.
interface operand_stack_if #(parameter int WIDTH = 8, parameter int DEPTH = 8);
    localparam int DW = $clog2(DEPTH + 1);
    logic [2:0]       se;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             err;
    modport master (output se, data, input tos, nos, depth, empty, full, err);
    modport slave  (input se, data, output tos, nos, depth, empty, full, err);
endinterface

// File: rtl/operand_stack.sv
// operand_stack: single-cycle operand stack with registered TOS/NOS, array-backed spill and sticky error.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    operand_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 3) ? $clog2(DEPTH - 2) : 1;
    typedef enum logic [2:0] {NONE, PUSH, POP, REPL, BIN, DUP, SWAP, CLR} op_t;
    op_t              op;
    logic [WIDTH-1:0] tos, nos, refill;
    logic [WIDTH-1:0] mem [DEPTH-2];
    logic [DW-1:0]    depth, need, wr_idx, rd_idx;
    logic             err, full, grow, bad, spill;
    assign op     = op_t'(bus.se);
    assign need   = (op == BIN || op == SWAP) ? DW'(2) :
                    (op == POP || op == REPL || op == DUP) ? DW'(1) : '0;
    assign grow   = op == PUSH || op == DUP;
    assign full   = depth == DW'(DEPTH);
    assign bad    = depth < need || (grow && full);
    assign spill  = grow && !bad && depth >= DW'(2);
    // Array holds entries 3..depth; its top lives at depth-3, the next free slot at depth-2.
    assign wr_idx = depth - DW'(2);
    assign rd_idx = depth - DW'(3);
    assign refill = depth >= DW'(3) ? mem[rd_idx[AW-1:0]] : '0;
    always_ff @(posedge clk)
        if (rst_n && spill) mem[wr_idx[AW-1:0]] <= nos;
    always_ff @(posedge clk) begin
        if (!rst_n || op == CLR) begin
            tos   <= '0;
            nos   <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else if (bad) begin
            err <= 1'b1;
        end else begin
            case (op)
                PUSH: begin tos <= bus.data; nos <= tos; depth <= depth + DW'(1); end
                POP:  begin tos <= nos; nos <= refill; depth <= depth - DW'(1); end
                REPL: tos <= bus.data;
                BIN:  begin tos <= bus.data; nos <= refill; depth <= depth - DW'(1); end
                DUP:  begin nos <= tos; depth <= depth + DW'(1); end
                SWAP: begin tos <= nos; nos <= tos; end
                default: ;
            endcase
        end
    end
    assign bus.tos   = tos;
    assign bus.nos   = nos;
    assign bus.depth = depth;
    assign bus.err   = err;
    assign bus.empty = depth == '0;
    assign bus.full  = full;
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed stack-effect sequence against a queue of hand-derived expected states.
module tb_operand_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [2:0] NONE = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                           BIN = 3'd4, DUP = 3'd5, SWAP = 3'd6, CLR = 3'd7;
    typedef struct {
        string      tag;
        logic [7:0] tos;
        logic [7:0] nos;
        int         depth;
        logic       err;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    exp_t exp_q[$];
    operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(string tag, string field, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    endtask
    task automatic step(string tag, logic r, logic [2:0] s, logic [7:0] d,
                        logic [7:0] et, logic [7:0] en, int ed, logic ee);
        exp_t e;
        exp_q.push_back('{tag, et, en, ed, ee});
        rst_n   = r;
        bus.se   = s;
        bus.data = d;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(e.tag, "tos", 32'(bus.tos), 32'(e.tos));
        chk(e.tag, "nos", 32'(bus.nos), 32'(e.nos));
        chk(e.tag, "depth", 32'(bus.depth), 32'(e.depth));
        chk(e.tag, "err", 32'(bus.err), 32'(e.err));
        chk(e.tag, "empty", 32'(bus.empty), 32'(e.depth == 0));
        chk(e.tag, "full", 32'(bus.full), 32'(e.depth == DEPTH));
    endtask
    initial begin
        bus.se   = NONE;
        bus.data = '0;
        step("reset",      0, PUSH, 8'hAA, 8'h00, 8'h00, 0, 0);
        step("push11",     1, PUSH, 8'h11, 8'h11, 8'h00, 1, 0);
        step("push22",     1, PUSH, 8'h22, 8'h22, 8'h11, 2, 0);
        step("push33",     1, PUSH, 8'h33, 8'h33, 8'h22, 3, 0);
        step("clr0",       1, CLR,  8'h00, 8'h00, 8'h00, 0, 0);
        step("push5",      1, PUSH, 8'h05, 8'h05, 8'h00, 1, 0);
        step("push3",      1, PUSH, 8'h03, 8'h03, 8'h05, 2, 0);
        step("bin_add",    1, BIN,  8'h08, 8'h08, 8'h00, 1, 0);
        step("clr1",       1, CLR,  8'h00, 8'h00, 8'h00, 0, 0);
        step("fill1",      1, PUSH, 8'h01, 8'h01, 8'h00, 1, 0);
        step("fill2",      1, PUSH, 8'h02, 8'h02, 8'h01, 2, 0);
        step("fill3",      1, PUSH, 8'h03, 8'h03, 8'h02, 3, 0);
        step("fill4",      1, PUSH, 8'h04, 8'h04, 8'h03, 4, 0);
        step("refill_a",   1, POP,  8'h00, 8'h03, 8'h02, 3, 0);
        step("refill_b",   1, POP,  8'h00, 8'h02, 8'h01, 2, 0);
        step("refill_c",   1, POP,  8'h00, 8'h01, 8'h00, 1, 0);
        step("refull2",    1, PUSH, 8'h02, 8'h02, 8'h01, 2, 0);
        step("refull3",    1, PUSH, 8'h03, 8'h03, 8'h02, 3, 0);
        step("refull4",    1, PUSH, 8'h04, 8'h04, 8'h03, 4, 0);
        step("overflow",   1, PUSH, 8'h99, 8'h04, 8'h03, 4, 1);
        step("pop_sticky", 1, POP,  8'h00, 8'h03, 8'h02, 3, 1);
        step("none",       1, NONE, 8'h5A, 8'h03, 8'h02, 3, 1);
        step("repl",       1, REPL, 8'h77, 8'h77, 8'h02, 3, 1);
        step("clr2",       1, CLR,  8'h00, 8'h00, 8'h00, 0, 0);
        step("pushA",      1, PUSH, 8'h0A, 8'h0A, 8'h00, 1, 0);
        step("pushB",      1, PUSH, 8'h0B, 8'h0B, 8'h0A, 2, 0);
        step("swap",       1, SWAP, 8'h00, 8'h0A, 8'h0B, 2, 0);
        step("dup",        1, DUP,  8'h00, 8'h0A, 8'h0A, 3, 0);
        step("dup_refill", 1, POP,  8'h00, 8'h0A, 8'h0B, 2, 0);
        step("clr3",       1, CLR,  8'h00, 8'h00, 8'h00, 0, 0);
        step("empty_pop",  1, POP,  8'h00, 8'h00, 8'h00, 0, 1);
        step("clr4",       1, CLR,  8'h00, 8'h00, 8'h00, 0, 0);
        step("single",     1, PUSH, 8'h42, 8'h42, 8'h00, 1, 0);
        step("bin_under",  1, BIN,  8'h99, 8'h42, 8'h00, 1, 1);
        step("swap_under", 1, SWAP, 8'h00, 8'h42, 8'h00, 1, 1);
        step("clr5",       1, CLR,  8'h00, 8'h00, 8'h00, 0, 0);
        step("push55",     1, PUSH, 8'h55, 8'h55, 8'h00, 1, 0);
        step("push66",     1, PUSH, 8'h66, 8'h66, 8'h55, 2, 0);
        step("mid_reset",  0, PUSH, 8'h77, 8'h00, 8'h00, 0, 0);
        step("post_reset", 1, NONE, 8'h00, 8'h00, 8'h00, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/operand_stack.md
# operand_stack

Single-cycle operand stack that sits directly upstream of the combinational ALU. It presents top-of-stack and next-on-stack as registered operands and accepts the ALU result back as the new top in the same clock. It applies one stack operation per clock: push, pop, replace, binary reduce, dup, swap or clear. It tracks depth and holds a sticky error flag for overflow and underflow.

## Interface
- WIDTH, 8, bits per element (matches ALU WIDTH)
- DEPTH, 8, maximum number of entries; must be >= 3
- i_clk  input  1  system clock; all state changes on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_se  input  3  stack-effect selector: 0 NONE, 1 PUSH, 2 POP, 3 REPL, 4 BIN, 5 DUP, 6 SWAP, 7 CLR
- i_data  input  WIDTH  value written by PUSH, REPL and BIN (normally ALU o_data)
- o_tos  output  WIDTH  top of stack, registered; 0 when depth = 0
- o_nos  output  WIDTH  next on stack, registered; 0 when depth < 2
- o_depth  output  $clog2(DEPTH+1)  current entry count, 0..DEPTH
- o_empty  output  1  depth = 0
- o_full  output  1  depth = DEPTH
- o_err  output  1  sticky overflow/underflow flag

## Operation
- Storage:
  - TOS and NOS are registers.
  - Entries 3..DEPTH live in a (DEPTH-2)-entry array indexed by a pointer derived from depth.
  - Array contents are don't-care until written; no reset of the array.
- Intended wiring: o_nos -> ALU i_arg0, o_tos -> ALU i_arg1, ALU o_data -> i_data.
  - Unary ALU ops (NO_OP, ROL) use REPL.
  - Binary ALU ops use BIN.
- Per-op requirement (k = operands needed, g = net growth):
  - NONE: k 0, g 0; no change.
  - PUSH: k 0, g +1; NOS <= TOS, TOS <= i_data, old NOS spills to array.
  - POP: k 1, g -1; TOS <= NOS, NOS <= array top (or 0 if new depth < 2).
  - REPL: k 1, g 0; TOS <= i_data.
  - BIN: k 2, g -1; TOS <= i_data, NOS <= array top (or 0 if new depth < 2).
  - DUP: k 1, g +1; NOS <= TOS, TOS unchanged, old NOS spills.
  - SWAP: k 2, g 0; TOS and NOS exchange.
  - CLR: depth <= 0, TOS <= 0, NOS <= 0, err <= 0.
- Underflow: depth < k. The op is suppressed (no register, array or depth change) and o_err <= 1.
- Overflow: g = +1 and depth = DEPTH. The op is suppressed and o_err <= 1.
- o_err stays set across subsequent valid ops. Only CLR or reset clears it.
- Vacated positions are zeroed:
  - POP/BIN to depth 1 forces NOS = 0.
  - POP to depth 0 forces TOS = 0.
- Depth arithmetic is unsigned. It never wraps, because the suppression rules guarantee 0 <= depth <= DEPTH.

## Timing
- Reset (i_rst_n low at a rising edge):
  - o_tos = 0, o_nos = 0, o_depth = 0, o_err = 0.
  - o_empty = 1, o_full = 0.
  - Reset overrides any i_se in the same cycle.
  - Reset mid-sequence discards all contents.
- Latency:
  - i_se/i_data sampled at rising edge N; o_tos, o_nos, o_depth and o_err are updated after edge N.
  - One op per clock; no stall, no back-pressure.
- BIN/REPL read-modify-write: i_data must be a combinational function of the current o_tos/o_nos. The stack samples it at the same edge, so the ALU adds no cycle.
- o_empty and o_full are decoded from registered depth. They introduce no combinational path from the inputs.
- A spill or refill against the array completes in the same edge. The array read uses the current pointer, so no read-latency bubble is permitted.

## Test plan
- Push sequence: reset; PUSH 0x11, 0x22, 0x33 -> depth 3, tos 0x33, nos 0x22, err 0.
- BIN with ALU ADD: PUSH 5, PUSH 3, BIN with i_data = 8 -> depth 1, tos 0x08, nos 0x00.
- Array spill/refill (DEPTH=4):
  - PUSH 1, 2, 3, 4.
  - POP x3 -> tos goes 3, 2, 1; nos goes 2, 1, 0; depth ends 1.
- Overflow (DEPTH=4):
  - Fill with 4 pushes, then PUSH 0x99 -> depth 4, tos 0x04 unchanged, err 1.
  - Then POP -> depth 3, tos 0x03, err still 1.
  - SWAP and DUP mix: PUSH 0xA, PUSH 0xB, SWAP -> tos 0xA, nos 0xB; DUP -> depth 3, tos 0xA, nos 0xA.
- Underflow and clear:
  - Empty POP -> depth 0, tos 0, err 1.
  - Single entry, then BIN -> suppressed, err 1.
  - CLR -> err 0, depth 0.
- Reset mid-operation: PUSH 0x55, PUSH 0x66, then assert i_rst_n low with i_se = PUSH -> depth 0, tos 0, nos 0, err 0, empty 1.
